alu_ctrl_seq: RTL and testbench
===============================

// Module: alu_ctrl_seq
// PURPOSE
//  Registered, sequenced successor to the combinational ALU control decoder of the multi-cycle CPU.
//  - Accepts one ALU request (aluop + one-hot func) per valid/ready handshake.
//  - Drives op / acc_wr / notnoop for one cycle, or for DATA_W cycles for iterative multiply.
//  - Reports done and flags illegal (non-one-hot) func words.
//  - Sits between the main controller FSM and the ALU / accumulator.
// PARAMETERS
//  DATA_W  16  datapath width; multiply runs exactly DATA_W step cycles (>=2)
//  FUNC_W  9   one-hot func width (>=9); bits [FUNC_W-1:9] are reserved and any set bit is illegal
// PORTS
//  clk        in   1          clock, all state updates on rising edge
//  rst        in   1          asynchronous, active-high reset
//  req_valid  in   1          request present
//  req_ready  out  1          request accepted when req_valid&&req_ready; = (state==IDLE)
//  aluop      in   3          000 add, 001 sub, 010 func-decoded, 011 and, 100 or, other -> pass B
//  func       in   FUNC_W     one-hot: b0 MoveTo, b1 MoveFrom, b2 Add, b3 Sub, b4 And, b5 Or, b6 Not, b7 Nop, b8 Mul
//  op         out  3          000 A&B, 001 A|B, 010 A+B, 011 A-B, 100 ~B, 101 A, 110 B, 111 MULSTEP
//  op_valid   out  1          op is meaningful this cycle
//  acc_wr     out  1          accumulator/coprocessor write strobe
//  notnoop    out  1          0 only during a Nop execute cycle
//  step_cnt   out  $clog2(DATA_W)  current multiply step index
//  busy       out  1          state != IDLE
//  done       out  1          one-cycle pulse on the last execute cycle of a request
//  illegal    out  1          one-cycle pulse with done when func was not one-hot (aluop=010 only)
// BEHAVIOUR
//  - Reset values: op=000, op_valid=0, acc_wr=0, notnoop=1, step_cnt=0, busy=0, done=0, illegal=0.
//  - Reset state is IDLE. Reset mid-request aborts it immediately: no done and no acc_wr are produced.
//  - States: IDLE, EXEC, ITER.
//  - IDLE: req_ready=1. On accept, aluop/func are decoded and outputs registered.
//    - Single-cycle op: -> EXEC.
//    - Mul: -> ITER with step_cnt=0.
//  - EXEC (one cycle): op_valid=1, done=1.
//    - acc_wr=1 only for MoveTo.
//    - Nop: op_valid=0, notnoop=0, acc_wr=0, done=1.
//    - Always -> IDLE.
//  - ITER: op=111, op_valid=1, step_cnt increments by 1 per cycle.
//    - On step_cnt==DATA_W-1: acc_wr=1, done=1, -> IDLE.
//    - No wrap: the counter clears on the exit to IDLE.
//  - Latency: accept at edge N -> outputs valid in cycle N+1.
//    - Single op: done in N+1, req_ready again in N+2; throughput is 1 request per 2 cycles.
//    - Mul: done in cycle N+DATA_W.
//  - req_valid and func changes outside IDLE are ignored; the decoded request is held internally.
//  - Decode when aluop!=010: func is ignored.
//  - Illegal func (aluop=010 with zero, multiple, or reserved bits set): executes as MoveFrom (op=110), illegal=1 with done.
//  - Outputs other than req_ready are registered; req_ready depends on state only, never on req_valid.
// CONFIGURATION
//  ALU_CTRL_MUL_EN defined:
//    - func b8 = Mul, sequenced through ITER as above.
//  ALU_CTRL_MUL_EN undefined:
//    - ITER and the step counter are not built; step_cnt is tied to 0.
//    - func b8 is treated as illegal: executes as MoveFrom with illegal=1.
//    - op=111 is never produced.
// TESTING
//  1. Reset: assert rst mid-cycle with no clock -> all outputs at reset values at once; release; req_ready=1.
//  2. aluop=010, func=9'h001 -> next cycle op=101, acc_wr=1, op_valid=1, done=1; following cycle req_ready=1.
//  3. aluop=010, func=9'h080 (Nop) -> next cycle notnoop=0, op_valid=0, acc_wr=0, done=1.
//  4. aluop=010, func=9'h00C (two bits) -> op=110, illegal=1, done=1. Also aluop=000 with func=9'h000 -> op=010, illegal=0.
//  5. MUL_EN, DATA_W=16, func=9'h100 -> 16 cycles op=111 with step_cnt 0..15; acc_wr and done only at step 15;
//     req_valid with func=9'h004 pulsed mid-run is ignored.
//  6. Mul, rst asserted at step 5 -> immediate IDLE, no done or acc_wr. Without MUL_EN, func=9'h100 -> op=110, illegal=1.

Source files
------------

// File: rtl/alu_ctrl_seq_if.sv
// ALU request/response bundle between the main controller FSM and alu_ctrl_seq.
interface alu_ctrl_seq_if #(
  parameter int DATA_W = 16,
  parameter int FUNC_W = 9
);
  localparam int CNT_W = $clog2(DATA_W);

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        aluop;
  logic [FUNC_W-1:0] func;
  logic [2:0]        op;
  logic              op_valid;
  logic              acc_wr;
  logic              notnoop;
  logic [CNT_W-1:0]  step_cnt;
  logic              busy;
  logic              done;
  logic              illegal;

  modport master (
    output req_valid, aluop, func,
    input  req_ready, op, op_valid, acc_wr, notnoop, step_cnt, busy, done, illegal
  );

  modport slave (
    input  req_valid, aluop, func,
    output req_ready, op, op_valid, acc_wr, notnoop, step_cnt, busy, done, illegal
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered, sequenced ALU control: one request per handshake, one EXEC cycle or DATA_W multiply steps.
// Optional feature: ALU_CTRL_MUL_EN builds the iterative multiply (ITER state and step counter).
module alu_ctrl_seq #(
  parameter int DATA_W = 16,
  parameter int FUNC_W = 9
) (
  input  logic           clk,
  input  logic           rst,
  alu_ctrl_seq_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, EXEC, ITER} state_t;

  state_t     state, state_nx;
  logic [2:0] op_q, op_nx;
  logic       op_valid_q, op_valid_nx;
  logic       acc_wr_q, acc_wr_nx;
  logic       notnoop_q, notnoop_nx;
  logic       done_q, done_nx;
  logic       illegal_q, illegal_nx;

  logic [2:0] dec_op;
  logic       dec_mov, dec_nop, dec_mul, dec_ill;

  // Illegal func words fall back to MoveFrom (pass B) so the datapath stays harmless.
  always_comb begin
    dec_op  = 3'b110;
    dec_mov = 1'b0;
    dec_nop = 1'b0;
    dec_mul = 1'b0;
    dec_ill = 1'b0;
    case (bus.aluop)
      3'b000: dec_op = 3'b010;
      3'b001: dec_op = 3'b011;
      3'b011: dec_op = 3'b000;
      3'b100: dec_op = 3'b001;
      3'b010: begin
        if (!$onehot(bus.func) || ((bus.func >> 9) != '0)) dec_ill = 1'b1;
        else if (bus.func[0]) begin dec_op = 3'b101; dec_mov = 1'b1; end
        else if (bus.func[1]) dec_op = 3'b110;
        else if (bus.func[2]) dec_op = 3'b010;
        else if (bus.func[3]) dec_op = 3'b011;
        else if (bus.func[4]) dec_op = 3'b000;
        else if (bus.func[5]) dec_op = 3'b001;
        else if (bus.func[6]) dec_op = 3'b100;
        else if (bus.func[7]) dec_nop = 1'b1;
`ifdef ALU_CTRL_MUL_EN
        else if (bus.func[8]) begin dec_op = 3'b111; dec_mul = 1'b1; end
`endif
        else dec_ill = 1'b1;
      end
      default: dec_op = 3'b110;
    endcase
  end

`ifdef ALU_CTRL_MUL_EN
  logic [CNT_W-1:0] cnt_q, cnt_nx;
`endif

  always_comb begin
    state_nx    = state;
    op_nx       = op_q;
    op_valid_nx = 1'b0;
    acc_wr_nx   = 1'b0;
    notnoop_nx  = 1'b1;
    done_nx     = 1'b0;
    illegal_nx  = 1'b0;
`ifdef ALU_CTRL_MUL_EN
    cnt_nx      = '0;
`endif
    case (state)
      IDLE: if (bus.req_valid) begin
        op_nx = dec_op;
        if (dec_mul) begin
          state_nx    = ITER;
          op_valid_nx = 1'b1;
        end else begin
          state_nx    = EXEC;
          op_valid_nx = !dec_nop;
          notnoop_nx  = !dec_nop;
          acc_wr_nx   = dec_mov;
          done_nx     = 1'b1;
          illegal_nx  = dec_ill;
        end
      end
      EXEC: state_nx = IDLE;
`ifdef ALU_CTRL_MUL_EN
      // Flags for the last step are set one edge early so they register with it.
      ITER: if (cnt_q == CNT_W'(DATA_W-1)) begin
        state_nx = IDLE;
      end else begin
        op_valid_nx = 1'b1;
        cnt_nx      = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W-2)) begin
          acc_wr_nx = 1'b1;
          done_nx   = 1'b1;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= 3'b000;
      op_valid_q <= 1'b0;
      acc_wr_q   <= 1'b0;
      notnoop_q  <= 1'b1;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
`ifdef ALU_CTRL_MUL_EN
      cnt_q      <= '0;
`endif
    end else begin
      state      <= state_nx;
      op_q       <= op_nx;
      op_valid_q <= op_valid_nx;
      acc_wr_q   <= acc_wr_nx;
      notnoop_q  <= notnoop_nx;
      done_q     <= done_nx;
      illegal_q  <= illegal_nx;
`ifdef ALU_CTRL_MUL_EN
      cnt_q      <= cnt_nx;
`endif
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.op        = op_q;
  assign bus.op_valid  = op_valid_q;
  assign bus.acc_wr    = acc_wr_q;
  assign bus.notnoop   = notnoop_q;
  assign bus.done      = done_q;
  assign bus.illegal   = illegal_q;
`ifdef ALU_CTRL_MUL_EN
  assign bus.step_cnt  = cnt_q;
`else
  assign bus.step_cnt  = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed self-checking bench for alu_ctrl_seq (DATA_W=16, FUNC_W=9).
module tb_alu_ctrl_seq;
  localparam int DATA_W = 16;
  localparam int FUNC_W = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_ctrl_seq_if #(.DATA_W(DATA_W), .FUNC_W(FUNC_W)) bus ();
  alu_ctrl_seq #(.DATA_W(DATA_W), .FUNC_W(FUNC_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Present one request, take the accept edge, and sample #1 later (cycle N+1).
  task automatic issue(input logic [2:0] a, input logic [8:0] f);
    bus.aluop = a; bus.func = f; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset;
    bus.req_valid = 1'b0; bus.aluop = 3'b000; bus.func = '0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(3'b010, 9'h001);
    // mid-cycle async reset while MoveTo outputs are active
    #2 rst = 1'b1; #1;
    n_checks++; if (bus.op !== 3'b000)    begin n_fail++; $display("FAIL rst_op got %b exp 000", bus.op); end
    n_checks++; if (bus.op_valid !== 1'b0) begin n_fail++; $display("FAIL rst_op_valid got %b exp 0", bus.op_valid); end
    n_checks++; if (bus.acc_wr !== 1'b0)  begin n_fail++; $display("FAIL rst_acc_wr got %b exp 0", bus.acc_wr); end
    n_checks++; if (bus.notnoop !== 1'b1) begin n_fail++; $display("FAIL rst_notnoop got %b exp 1", bus.notnoop); end
    n_checks++; if (bus.step_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_step_cnt got %0d exp 0", bus.step_cnt); end
    n_checks++; if (bus.busy !== 1'b0)    begin n_fail++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0)    begin n_fail++; $display("FAIL rst_done got %b exp 0", bus.done); end
    n_checks++; if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL rst_illegal got %b exp 0", bus.illegal); end
    @(posedge clk); #1 rst = 1'b0; #1;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got %b exp 1", bus.req_ready); end
  endtask

  task automatic test_moveto;
    issue(3'b010, 9'h001);
    n_checks++; if (bus.op !== 3'b101)     begin n_fail++; $display("FAIL mov_op got %b exp 101", bus.op); end
    n_checks++; if (bus.acc_wr !== 1'b1)   begin n_fail++; $display("FAIL mov_acc_wr got %b exp 1", bus.acc_wr); end
    n_checks++; if (bus.op_valid !== 1'b1) begin n_fail++; $display("FAIL mov_op_valid got %b exp 1", bus.op_valid); end
    n_checks++; if (bus.done !== 1'b1)     begin n_fail++; $display("FAIL mov_done got %b exp 1", bus.done); end
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL mov_ready_exec got %b exp 0", bus.req_ready); end
    n_checks++; if (bus.busy !== 1'b1)     begin n_fail++; $display("FAIL mov_busy got %b exp 1", bus.busy); end
    @(posedge clk); #1;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL mov_ready_after got %b exp 1", bus.req_ready); end
    n_checks++; if ({bus.done, bus.acc_wr, bus.op_valid} !== 3'b000) begin n_fail++; $display("FAIL mov_idle_flags got %b exp 000", {bus.done, bus.acc_wr, bus.op_valid}); end
  endtask

  task automatic test_nop;
    issue(3'b010, 9'h080);
    n_checks++; if (bus.notnoop !== 1'b0)  begin n_fail++; $display("FAIL nop_notnoop got %b exp 0", bus.notnoop); end
    n_checks++; if (bus.op_valid !== 1'b0) begin n_fail++; $display("FAIL nop_op_valid got %b exp 0", bus.op_valid); end
    n_checks++; if (bus.acc_wr !== 1'b0)   begin n_fail++; $display("FAIL nop_acc_wr got %b exp 0", bus.acc_wr); end
    n_checks++; if (bus.done !== 1'b1)     begin n_fail++; $display("FAIL nop_done got %b exp 1", bus.done); end
    @(posedge clk); #1;
    n_checks++; if (bus.notnoop !== 1'b1)  begin n_fail++; $display("FAIL nop_notnoop_after got %b exp 1", bus.notnoop); end
  endtask

  task automatic test_illegal;
    logic [8:0] fv [3];
    fv[0] = 9'h00C; fv[1] = 9'h000; fv[2] = 9'h1FF;
    for (int i = 0; i < 3; i++) begin
      issue(3'b010, fv[i]);
      n_checks++; if ({bus.op, bus.illegal, bus.done, bus.acc_wr} !== 6'b110_1_1_0) begin
        n_fail++; $display("FAIL illegal_%0d op/ill/done/wr got %b exp 110110", i, {bus.op, bus.illegal, bus.done, bus.acc_wr}); end
      @(posedge clk); #1;
    end
    issue(3'b000, 9'h000);
    n_checks++; if ({bus.op, bus.illegal} !== 4'b010_0) begin
      n_fail++; $display("FAIL add_func_ignored op/ill got %b exp 0100", {bus.op, bus.illegal}); end
    @(posedge clk); #1;
  endtask

  task automatic test_decode;
    logic [2:0] av [11];
    logic [8:0] fv [11];
    logic [2:0] ev [11];
    av = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b111, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
    fv = '{9'h004, 9'h003, 9'h000, 9'h000, 9'h000, 9'h100, 9'h002, 9'h004, 9'h008, 9'h010, 9'h020};
    ev = '{3'b010, 3'b011, 3'b000, 3'b001, 3'b110, 3'b110, 3'b110, 3'b010, 3'b011, 3'b000, 3'b001};
    for (int i = 0; i < 11; i++) begin
      issue(av[i], fv[i]);
      n_checks++; if ({bus.op, bus.illegal, bus.acc_wr} !== {ev[i], 2'b00}) begin
        n_fail++; $display("FAIL decode_%0d op/ill/wr got %b exp %b", i, {bus.op, bus.illegal, bus.acc_wr}, {ev[i], 2'b00}); end
      @(posedge clk); #1;
    end
    issue(3'b010, 9'h040);
    n_checks++; if (bus.op !== 3'b100) begin n_fail++; $display("FAIL decode_not op got %b exp 100", bus.op); end
    @(posedge clk); #1;
  endtask

  // req_valid held high: accepts every other cycle, changes during EXEC ignored.
  task automatic test_back_to_back;
    logic [3:0] seen;
    bus.aluop = 3'b001; bus.func = '0; bus.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seen[i] = bus.done;
      if (i == 0) bus.aluop = 3'b100;
    end
    bus.req_valid = 1'b0;
    n_checks++; if (seen !== 4'b0101) begin n_fail++; $display("FAIL b2b_done_pattern got %b exp 0101", seen); end
    n_checks++; if (bus.op !== 3'b001) begin n_fail++; $display("FAIL b2b_second_op got %b exp 001", bus.op); end
    @(posedge clk); #1;
  endtask

`ifdef ALU_CTRL_MUL_EN
  task automatic test_mul;
    issue(3'b010, 9'h100);
    for (int i = 0; i < DATA_W; i++) begin
      n_checks++; if ({bus.op, bus.op_valid, bus.step_cnt} !== {3'b111, 1'b1, 4'(i)}) begin
        n_fail++; $display("FAIL mul_step_%0d op/vld/cnt got %b exp %b", i, {bus.op, bus.op_valid, bus.step_cnt}, {3'b111, 1'b1, 4'(i)}); end
      n_checks++; if ({bus.acc_wr, bus.done} !== {2{i == DATA_W-1}}) begin
        n_fail++; $display("FAIL mul_flags_%0d wr/done got %b exp %b", i, {bus.acc_wr, bus.done}, {2{i == DATA_W-1}}); end
      if (i == 6) begin bus.aluop = 3'b010; bus.func = 9'h004; bus.req_valid = 1'b1; end
      if (i == 7) bus.req_valid = 1'b0;
      @(posedge clk); #1;
    end
    n_checks++; if ({bus.req_ready, bus.busy, bus.done, bus.step_cnt} !== 7'b1000000) begin
      n_fail++; $display("FAIL mul_exit rdy/busy/done/cnt got %b exp 1000000", {bus.req_ready, bus.busy, bus.done, bus.step_cnt}); end
    issue(3'b010, 9'h100);
    repeat (5) begin @(posedge clk); #1; end
    n_checks++; if (bus.step_cnt !== 4'd5) begin n_fail++; $display("FAIL mul_abort_step got %0d exp 5", bus.step_cnt); end
    #2 rst = 1'b1; #1;
    n_checks++; if ({bus.busy, bus.done, bus.acc_wr, bus.op_valid, bus.step_cnt} !== 8'b0) begin
      n_fail++; $display("FAIL mul_abort got %b exp 00000000", {bus.busy, bus.done, bus.acc_wr, bus.op_valid, bus.step_cnt}); end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      @(posedge clk); #1;
      n_checks++; if ({bus.done, bus.acc_wr} !== 2'b00) begin
        n_fail++; $display("FAIL mul_abort_quiet_%0d got %b exp 00", i, {bus.done, bus.acc_wr}); end
    end
  endtask
`else
  task automatic test_mul;
    issue(3'b010, 9'h100);
    n_checks++; if ({bus.op, bus.illegal, bus.done, bus.step_cnt} !== {3'b110, 2'b11, 4'd0}) begin
      n_fail++; $display("FAIL nomul got %b exp %b", {bus.op, bus.illegal, bus.done, bus.step_cnt}, {3'b110, 2'b11, 4'd0}); end
    @(posedge clk); #1;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL nomul_ready got %b exp 1", bus.req_ready); end
  endtask
`endif

  initial begin
    test_reset;
    test_moveto;
    test_nop;
    test_illegal;
    test_decode;
    test_back_to_back;
    test_mul;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
